// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: 2-stage pipeline from raster timing to registered sync/RGB.
// Optional white frame border when PATTERN_BORDER_EN is defined.
module vga_pattern_gen #(
    parameter int unsigned BAR_SPEED  = 4,
    parameter int unsigned CHECK_LOG2 = 5,
    parameter int unsigned BAR_WIDTH  = 16
) (
    input  logic       pixelClk,
    input  logic       reset,
    input  logic       hClk,
    input  logic       hVis,
    input  logic [9:0] xCor,
    input  logic       vClk,
    input  logic       vVis,
    input  logic [9:0] yCor,
    input  logic [1:0] modeSel,
    output logic       hSync,
    output logic       vSync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frameStart,
    output logic [7:0] frameCount
);

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_MOVING   = 2'd3
    } mode_t;

    mode_t       mode;
    logic [9:0]  bar_x;
    logic [9:0]  bar_next;
    logic [10:0] bar_sum;
    logic        frame_hit_in;

    logic        s1_hclk;
    logic        s1_vclk;
    logic        s1_vis;
    logic [9:0]  s1_x;
    logic        s1_frame_hit;
    logic        s1_ybit;
`ifdef PATTERN_BORDER_EN
    logic [9:0]  s1_y;
    assign s1_ybit = s1_y[CHECK_LOG2];
`else
    // Only the checker bit of yCor is consumed without the border feature.
    logic        s1_ychk;
    assign s1_ybit = s1_ychk;
`endif

    logic [11:0] pix_rgb;
    logic [2:0]  bar_idx;
    logic [3:0]  grey;

    assign frame_hit_in = (xCor == '0) && (yCor == '0);

    always_comb begin
        bar_sum  = {1'b0, bar_x} + 11'(BAR_SPEED);
        bar_next = (bar_sum >= 11'd640) ? 10'(bar_sum - 11'd640) : bar_sum[9:0];
    end

    always_ff @(posedge pixelClk) begin
        if (reset) begin
            s1_hclk      <= 1'b1;
            s1_vclk      <= 1'b1;
            s1_vis       <= 1'b0;
            s1_x         <= '0;
            s1_frame_hit <= 1'b0;
`ifdef PATTERN_BORDER_EN
            s1_y         <= '0;
`else
            s1_ychk      <= 1'b0;
`endif
            mode         <= MODE_BARS;
            bar_x        <= '0;
            frameCount   <= '0;
        end else begin
            s1_hclk      <= hClk;
            s1_vclk      <= vClk;
            s1_vis       <= hVis & vVis;
            s1_x         <= xCor;
            s1_frame_hit <= frame_hit_in;
`ifdef PATTERN_BORDER_EN
            s1_y         <= yCor;
`else
            s1_ychk      <= yCor[CHECK_LOG2];
`endif
            if (frame_hit_in) begin
                mode       <= mode_t'(modeSel);
                frameCount <= frameCount + 8'd1;
                if (mode_t'(modeSel) == MODE_MOVING)
                    bar_x <= bar_next;
            end
        end
    end

    // Bar and grey indices by threshold counting rather than division.
    always_comb begin
        bar_idx = '0;
        grey    = '0;
        for (int unsigned k = 1; k < 8; k++)
            if (32'(s1_x) >= 80 * k) bar_idx = bar_idx + 3'd1;
        for (int unsigned k = 1; k < 16; k++)
            if (32'(s1_x) >= 40 * k) grey = grey + 4'd1;
    end

    always_comb begin
        pix_rgb = '0;
        if (s1_vis) begin
            unique case (mode)
                MODE_BARS: begin
                    unique case (bar_idx)
                        3'd0:    pix_rgb = 12'hFFF;
                        3'd1:    pix_rgb = 12'hFF0;
                        3'd2:    pix_rgb = 12'h0FF;
                        3'd3:    pix_rgb = 12'h0F0;
                        3'd4:    pix_rgb = 12'hF0F;
                        3'd5:    pix_rgb = 12'hF00;
                        3'd6:    pix_rgb = 12'h00F;
                        default: pix_rgb = 12'h000;
                    endcase
                end
                MODE_CHECKER:
                    pix_rgb = (s1_x[CHECK_LOG2] ^ s1_ybit) ? 12'hFFF : 12'h000;
                MODE_GRADIENT:
                    pix_rgb = {grey, grey, grey};
                default: begin
                    if ({1'b0, s1_x} >= {1'b0, bar_x} &&
                        {1'b0, s1_x} < {1'b0, bar_x} + 11'(BAR_WIDTH))
                        pix_rgb = 12'hFFF;
                    else
                        pix_rgb = 12'h004;
                end
            endcase
`ifdef PATTERN_BORDER_EN
            if (s1_x == 10'd0 || s1_x == 10'd639 || s1_y == 10'd0 || s1_y == 10'd479)
                pix_rgb = 12'hFFF;
`endif
        end
    end

    always_ff @(posedge pixelClk) begin
        if (reset) begin
            hSync      <= 1'b1;
            vSync      <= 1'b1;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            frameStart <= 1'b0;
        end else begin
            hSync      <= s1_hclk;
            vSync      <= s1_vclk;
            red        <= pix_rgb[11:8];
            green      <= pix_rgb[7:4];
            blue       <= pix_rgb[3:0];
            frameStart <= s1_frame_hit;
        end
    end

endmodule
